// File: rtl/mips_core_pkg.sv
// Shared core types plus the branch-predictor table arbiter definitions.
package mips_core_pkg;

    localparam int unsigned ADDR_WIDTH        = 32;
    localparam int unsigned BP_MAX_INDEX_BITS = 16;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef logic [1:0] pht_counter_t;

    localparam pht_counter_t PHT_INIT = 2'b01;

    // Index is stored at the maximum supported width; users keep the low INDEX_BITS.
    typedef struct packed {
        logic [BP_MAX_INDEX_BITS-1:0] index;
        BranchOutcome                 outcome;
    } bp_update_t;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        UPD_WR = 2'd2
    } bp_arb_state_t;

    function automatic pht_counter_t pht_next(input pht_counter_t c, input BranchOutcome o);
        if (o == TAKEN) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/bp_table_arbiter_update_fifo.sv
// Feedback queue: in-order FIFO of PHT updates, push and pop allowed together even when full.
module bp_update_fifo
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  bp_update_t i_data,
    input  logic       i_pop,
    output bp_update_t o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    bp_update_t        mem_q [DEPTH];
    bp_update_t        mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (i_push && !i_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (!i_push && i_pop) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_full  = (count_q == (PW+1)'(DEPTH));
    assign o_empty = (count_q == '0);

endmodule

// File: rtl/bp_table_arbiter.sv
// PHT port arbiter: clears the table, serves predictions first, and applies queued
// feedback as read-modify-write pairs.
module bp_table_arbiter
    import mips_core_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output logic                  o_req_ready,
    output logic                  o_pred_valid,
    output BranchOutcome          o_req_prediction,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  BranchOutcome          i_fb_outcome,
    output logic                  o_fb_drop,
    output logic [7:0]            o_drop_count,
    output logic                  o_init_done,
    output logic                  o_tbl_en,
    output logic                  o_tbl_we,
    output logic [INDEX_BITS-1:0] o_tbl_addr,
    output logic [1:0]            o_tbl_wdata,
    input  logic [1:0]            i_tbl_rdata
);

    localparam int unsigned        NUM_ENTRIES = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NUM_ENTRIES - 1);

    bp_arb_state_t         state_q, state_d;
    logic                  arm_q, arm_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [INDEX_BITS-1:0] upd_idx_q, upd_idx_d;
    BranchOutcome          upd_out_q, upd_out_d;
    logic                  pred_valid_q, pred_valid_d;
    BranchOutcome          pred_hold_q, pred_hold_d;
    logic                  init_done_q, init_done_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    bp_update_t            fifo_head, fb_entry;
    logic [INDEX_BITS-1:0] req_idx;
    logic                  unused_bits;

    assign req_idx  = i_req_pc[INDEX_BITS+1:2];
    assign fb_entry = '{index: BP_MAX_INDEX_BITS'(i_fb_pc[INDEX_BITS+1:2]), outcome: i_fb_outcome};

    assign unused_bits = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                           i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0],
                           fifo_head.index[BP_MAX_INDEX_BITS-1:INDEX_BITS]};

    bp_update_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (fifo_push),
        .i_data  (fb_entry),
        .i_pop   (fifo_pop),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Next state, table command and bookkeeping.
    always_comb begin
        state_d      = state_q;
        arm_d        = 1'b1;
        init_idx_d   = init_idx_q;
        upd_idx_d    = upd_idx_q;
        upd_out_d    = upd_out_q;
        pred_valid_d = 1'b0;
        init_done_d  = init_done_q;
        drop_cnt_d   = drop_cnt_q;
        fifo_pop     = 1'b0;
        o_tbl_en     = 1'b0;
        o_tbl_we     = 1'b0;
        o_tbl_addr   = '0;
        o_tbl_wdata  = '0;

        // Table data only belongs to us in the cycle after a prediction read.
        pred_hold_d  = pred_valid_q ? BranchOutcome'(i_tbl_rdata[1]) : pred_hold_q;

        case (state_q)
            INIT: begin
                if (arm_q) begin
                    o_tbl_en    = 1'b1;
                    o_tbl_we    = 1'b1;
                    o_tbl_addr  = init_idx_q;
                    o_tbl_wdata = PHT_INIT;
                    init_idx_d  = init_idx_q + INDEX_BITS'(1);
                    if (init_idx_q == LAST_IDX) begin
                        state_d     = RUN;
                        init_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (fifo_full || (!i_req_valid && !fifo_empty)) begin
                    fifo_pop   = 1'b1;
                    o_tbl_en   = 1'b1;
                    o_tbl_addr = INDEX_BITS'(fifo_head.index);
                    upd_idx_d  = INDEX_BITS'(fifo_head.index);
                    upd_out_d  = fifo_head.outcome;
                    state_d    = UPD_WR;
                end else if (i_req_valid) begin
                    o_tbl_en     = 1'b1;
                    o_tbl_addr   = req_idx;
                    pred_valid_d = 1'b1;
                end
            end
            UPD_WR: begin
                o_tbl_en    = 1'b1;
                o_tbl_we    = 1'b1;
                o_tbl_addr  = upd_idx_q;
                o_tbl_wdata = pht_next(i_tbl_rdata, upd_out_q);
                state_d     = RUN;
            end
            default: state_d = INIT;
        endcase

        // A full queue still accepts feedback when it is draining in the same cycle.
        fifo_push = i_fb_valid && (!fifo_full || fifo_pop);
        o_fb_drop = i_fb_valid && fifo_full && !fifo_pop;
        if (o_fb_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            arm_q        <= 1'b0;
            init_idx_q   <= '0;
            upd_idx_q    <= '0;
            upd_out_q    <= NOT_TAKEN;
            pred_valid_q <= 1'b0;
            pred_hold_q  <= NOT_TAKEN;
            init_done_q  <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            arm_q        <= arm_d;
            init_idx_q   <= init_idx_d;
            upd_idx_q    <= upd_idx_d;
            upd_out_q    <= upd_out_d;
            pred_valid_q <= pred_valid_d;
            pred_hold_q  <= pred_hold_d;
            init_done_q  <= init_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign o_req_ready      = (state_q == RUN) && !fifo_full;
    assign o_pred_valid     = pred_valid_q;
    assign o_req_prediction = pred_hold_d;
    assign o_init_done      = init_done_q;
    assign o_drop_count     = drop_cnt_q;

endmodule

// File: tb/tb_bp_table_arbiter.sv
// Directed bench for bp_table_arbiter with a behavioural synchronous-read PHT.
module tb_bp_table_arbiter;
    import mips_core_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_v;
    logic [31:0]  req_pc;
    logic         rdy;
    logic         pv;
    BranchOutcome pred;
    logic         fb_v;
    logic [31:0]  fb_pc;
    BranchOutcome fb_out;
    logic         drop;
    logic [7:0]   drop_cnt;
    logic         init_done;
    logic         tbl_en, tbl_we;
    logic [5:0]   tbl_addr;
    logic [1:0]   tbl_wdata;
    logic [1:0]   tbl_rdata;

    int checks = 0;
    int errors = 0;

    logic [1:0] pht [64];

    bp_table_arbiter #(.INDEX_BITS(6), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (req_v),
        .i_req_pc         (req_pc),
        .o_req_ready      (rdy),
        .o_pred_valid     (pv),
        .o_req_prediction (pred),
        .i_fb_valid       (fb_v),
        .i_fb_pc          (fb_pc),
        .i_fb_outcome     (fb_out),
        .o_fb_drop        (drop),
        .o_drop_count     (drop_cnt),
        .o_init_done      (init_done),
        .o_tbl_en         (tbl_en),
        .o_tbl_we         (tbl_we),
        .o_tbl_addr       (tbl_addr),
        .o_tbl_wdata      (tbl_wdata),
        .i_tbl_rdata      (tbl_rdata)
    );

    always #5 clk = ~clk;

    // Memory is scribbled with 2'b10 while in reset so the clear sequence is observable.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) pht[i] <= 2'b10;
        end else if (tbl_en) begin
            if (tbl_we) pht[tbl_addr] <= tbl_wdata;
            else        tbl_rdata     <= pht[tbl_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        req_v;
        logic [31:0] req_pc;
        logic        fb_v;
        logic [31:0] fb_pc;
        logic        fb_tk;
        logic        rdy, en, we;
        logic [5:0]  addr;
        logic [1:0]  wdata;
        logic        pv, pr, drop;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic fv,
                                input logic [31:0] fpc, input logic ftk, input logic e_rdy,
                                input logic e_en, input logic e_we, input logic [5:0] e_addr,
                                input logic [1:0] e_wd, input logic e_pv, input logic e_pr,
                                input logic e_drop);
        vec_t v;
        v.req_v = rv;  v.req_pc = rpc; v.fb_v = fv; v.fb_pc = fpc; v.fb_tk = ftk;
        v.rdy = e_rdy; v.en = e_en; v.we = e_we; v.addr = e_addr; v.wdata = e_wd;
        v.pv = e_pv;   v.pr = e_pr; v.drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic fv,
                         input logic [31:0] fpc, input logic ftk);
        req_v  = rv;
        req_pc = rpc;
        fb_v   = fv;
        fb_pc  = fpc;
        fb_out = ftk ? TAKEN : NOT_TAKEN;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rst_ctl"}, 32'({rdy, pv, pred, drop, init_done}), 32'd0);
        chk({tag, "_rst_tbl"}, 32'({tbl_en, tbl_we, tbl_addr, tbl_wdata}), 32'd0);
        chk({tag, "_rst_dropcnt"}, 32'(drop_cnt), 32'd0);
    endtask

    // Called at posedge+1 with rst_n low; releases reset and checks the whole clear.
    task automatic release_and_check_init(input string tag);
        int bad;
        int w;
        bad = 0;
        w   = 0;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #2;
        while (!tbl_en && w < 4) begin
            cyc(); #2; w++;
        end
        chk({tag, "_init_start"}, 32'(tbl_en), 32'd1);
        for (int k = 0; k < 64; k++) begin
            if (!(tbl_en && tbl_we && tbl_addr == 6'(k) && tbl_wdata == 2'b01 &&
                  !init_done && !rdy)) bad++;
            cyc(); #2;
        end
        chk({tag, "_init_writes_bad"}, 32'(bad), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
        chk({tag, "_run_idle_en"}, 32'(tbl_en), 32'd0);
        chk({tag, "_run_ready"}, 32'(rdy), 32'd1);
        cyc();
    endtask

    vec_t vecs[20];
    int   e_rdy  [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
    int   e_we   [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    int   e_addr [8] = '{16, 16, 16, 8, 8, 8, 8, 16};
    int   e_drop [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int   e_pv   [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int   e_fbv  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    int   e_fbtk [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        //            req         fb            rdy en we addr wd pv pr drop
        vecs[0]  = mk(1, 'h10, 0, 0,     0,  1, 1, 0, 4, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0,    0, 0,     0,  1, 0, 0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0,    1, 'h10,  1,  1, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0,    1, 'h10,  1,  1, 1, 0, 4, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0,    0, 0,     0,  0, 1, 1, 4, 2, 0, 0, 0);
        vecs[5]  = mk(0, 0,    0, 0,     0,  1, 1, 0, 4, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0,    0, 0,     0,  0, 1, 1, 4, 3, 0, 0, 0);
        vecs[7]  = mk(1, 'h10, 0, 0,     0,  1, 1, 0, 4, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0,    0, 0,     0,  1, 0, 0, 0, 0, 1, 1, 0);
        vecs[9]  = mk(0, 0,    1, 'h10,  0,  1, 0, 0, 0, 0, 0, 1, 0);
        vecs[10] = mk(0, 0,    1, 'h10,  0,  1, 1, 0, 4, 0, 0, 1, 0);
        vecs[11] = mk(0, 0,    1, 'h10,  0,  0, 1, 1, 4, 2, 0, 1, 0);
        vecs[12] = mk(0, 0,    1, 'h10,  0,  1, 1, 0, 4, 0, 0, 1, 0);
        vecs[13] = mk(0, 0,    0, 0,     0,  0, 1, 1, 4, 1, 0, 1, 0);
        vecs[14] = mk(0, 0,    0, 0,     0,  1, 1, 0, 4, 0, 0, 1, 0);
        vecs[15] = mk(0, 0,    0, 0,     0,  0, 1, 1, 4, 0, 0, 1, 0);
        vecs[16] = mk(0, 0,    0, 0,     0,  1, 1, 0, 4, 0, 0, 1, 0);
        vecs[17] = mk(0, 0,    0, 0,     0,  0, 1, 1, 4, 0, 0, 1, 0);
        vecs[18] = mk(1, 'h10, 0, 0,     0,  1, 1, 0, 4, 0, 0, 1, 0);
        vecs[19] = mk(0, 0,    0, 0,     0,  1, 0, 0, 0, 0, 1, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        cyc();
        chk_reset_outputs("boot");
        cyc(); cyc();
        release_and_check_init("boot");

        // Prediction, saturating increment and decrement on index 4.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].req_v, vecs[i].req_pc, vecs[i].fb_v, vecs[i].fb_pc, vecs[i].fb_tk);
            #2;
            chk($sformatf("v%0d_ready", i), 32'(rdy), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_tbl_en", i), 32'(tbl_en), 32'(vecs[i].en));
            chk($sformatf("v%0d_tbl_we", i), 32'(tbl_we), 32'(vecs[i].we));
            if (vecs[i].en) chk($sformatf("v%0d_tbl_addr", i), 32'(tbl_addr), 32'(vecs[i].addr));
            if (vecs[i].we) chk($sformatf("v%0d_tbl_wdata", i), 32'(tbl_wdata), 32'(vecs[i].wdata));
            chk($sformatf("v%0d_pred_valid", i), 32'(pv), 32'(vecs[i].pv));
            chk($sformatf("v%0d_prediction", i), 32'(pred), 32'(vecs[i].pr));
            chk($sformatf("v%0d_fb_drop", i), 32'(drop), 32'(vecs[i].drop));
            cyc();
        end

        // One queued update stays deferred behind back-to-back predictions.
        drive(1, 'h40, 1, 'h20, 1);
        #2;
        chk("defer_first_read", 32'({rdy, tbl_en, tbl_we, tbl_addr}), 32'({3'b110, 6'd16}));
        cyc();
        for (int k = 0; k < 6; k++) begin
            drive(1, 'h40, 0, 0, 0);
            #2;
            chk($sformatf("defer_c%0d", k), 32'({rdy, tbl_en, tbl_we, tbl_addr, pv}),
                32'({3'b110, 6'd16, 1'b1}));
            cyc();
        end

        // Five consecutive feedbacks under continuous requests: fill, drain, one drop.
        for (int k = 0; k < 8; k++) begin
            drive(1, 'h40, 1'(e_fbv[k]), 'h20, 1'(e_fbtk[k]));
            #2;
            chk($sformatf("fill_c%0d_ready", k), 32'(rdy), 32'(e_rdy[k]));
            chk($sformatf("fill_c%0d_cmd", k), 32'({tbl_en, tbl_we, tbl_addr}),
                32'({1'b1, 1'(e_we[k]), 6'(e_addr[k])}));
            chk($sformatf("fill_c%0d_drop", k), 32'(drop), 32'(e_drop[k]));
            chk($sformatf("fill_c%0d_pv", k), 32'(pv), 32'(e_pv[k]));
            if (k == 4) chk("fill_c4_wdata", 32'(tbl_wdata), 32'd2);
            if (k == 6) chk("fill_c6_wdata", 32'(tbl_wdata), 32'd3);
            if (k == 5) chk("fill_drop_count", 32'(drop_cnt), 32'd1);
            cyc();
        end
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0, 0);
            #2;
            if (k % 2 == 0)
                chk($sformatf("drain_d%0d_read", k), 32'({tbl_en, tbl_we, tbl_addr}),
                    32'({2'b10, 6'd8}));
            else
                chk($sformatf("drain_d%0d_write", k), 32'({tbl_en, tbl_we, tbl_addr, tbl_wdata}),
                    32'({2'b11, 6'd8, 2'b11}));
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        #2;
        chk("drain_idle_en", 32'(tbl_en), 32'd0);
        chk("drain_pht8", 32'(pht[8]), 32'd3);
        chk("drain_drop_count", 32'(drop_cnt), 32'd1);
        cyc();

        // Two back-to-back TAKEN updates to index 12 must compose: 01 -> 10 -> 11.
        drive(0, 0, 1, 'h30, 1); #2;
        chk("same_c0_en", 32'(tbl_en), 32'd0);
        cyc();
        drive(0, 0, 1, 'h30, 1); #2;
        chk("same_c1_read", 32'({tbl_en, tbl_we, tbl_addr}), 32'({2'b10, 6'd12}));
        cyc();
        drive(0, 0, 0, 0, 0); #2;
        chk("same_c2_write", 32'({tbl_we, tbl_addr, tbl_wdata}), 32'({1'b1, 6'd12, 2'b10}));
        cyc();
        #2;
        chk("same_c3_read", 32'({tbl_en, tbl_we, tbl_addr}), 32'({2'b10, 6'd12}));
        cyc();
        #2;
        chk("same_c4_write", 32'({tbl_we, tbl_addr, tbl_wdata}), 32'({1'b1, 6'd12, 2'b11}));
        cyc();
        #2;
        chk("same_pht12", 32'(pht[12]), 32'd3);
        cyc();
        drive(1, 'h30, 0, 0, 0); #2;
        cyc();
        drive(0, 0, 0, 0, 0); #2;
        chk("same_pred", 32'({pv, pred}), 32'({1'b1, TAKEN}));
        cyc();

        // Reset during an update write with three entries still queued.
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 1, 32'h50 + 32'(4 * k), 1);
            #2;
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        #2;
        chk("mid_pre_upd", 32'({rdy, tbl_we}), 32'({1'b0, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid");
        cyc(); cyc();
        release_and_check_init("mid");
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0);
            #2;
            chk($sformatf("mid_fifo_empty_c%0d", k), 32'(tbl_en), 32'd0);
            cyc();
        end
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 64; i++) if (pht[i] !== 2'b01) bad++;
            chk("mid_pht_all_01_bad", 32'(bad), 32'd0);
        end
        drive(1, 'h50, 0, 0, 0); #2;
        chk("mid_pred_read", 32'({tbl_en, tbl_we, tbl_addr}), 32'({2'b10, 6'd20}));
        cyc();
        drive(0, 0, 0, 0, 0); #2;
        chk("mid_pred", 32'({pv, pred}), 32'({1'b1, NOT_TAKEN}));
        chk("mid_drop_count", 32'(drop_cnt), 32'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
